// File: rtl/filter_ewma_mc_if.sv
// Sample-in / result-out handshake bundle for the multi-channel EWMA filter.
// master drives samples and out_ready; slave is the filter.
interface filter_ewma_mc_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ALPHA_W  = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [CH_W-1:0]    in_chan;
  logic [DATA_W-1:0]  in_data;
  logic [ALPHA_W-1:0] in_alpha;
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_chan;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_chan, in_data, in_alpha, out_ready,
    input  in_ready, out_valid, out_chan, out_data
  );

  modport slave (
    input  in_valid, in_chan, in_data, in_alpha, out_ready,
    output in_ready, out_valid, out_chan, out_data
  );
endinterface

// File: rtl/filter_ewma_mc.sv
// Time-multiplexed EWMA low-pass filter: CHANNELS independent signed filters sharing one
// two-stage multiply/accumulate pipeline, with first-sample priming and rounding.
module filter_ewma_mc #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ALPHA_W  = 8,
  parameter int unsigned CHANNELS = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              clear,
  filter_ewma_mc_if.slave  bus
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int          Slots = 1 << CH_W;
  localparam int unsigned FullW = DATA_W + ALPHA_W + 2;
  localparam logic signed [FullW-1:0] Scale = FullW'(1) << ALPHA_W;
  localparam logic signed [FullW-1:0] Half  = FullW'(1) << (ALPHA_W - 1);

  // Per-channel filter state, padded to a power of two so any in_chan indexes safely.
  logic signed [DATA_W-1:0]  state_q [Slots];
  logic signed [DATA_W-1:0]  state_d [Slots];
  logic [Slots-1:0]          primed_q, primed_d;

  logic                      s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]           s1_chan_q, s1_chan_d;
  logic signed [DATA_W-1:0]  s1_x_q, s1_x_d;
  logic [ALPHA_W-1:0]        s1_alpha_q, s1_alpha_d;
  logic                      s1_primed_q, s1_primed_d;
  logic signed [DATA_W-1:0]  s1_state_q, s1_state_d;

  logic                      out_valid_q, out_valid_d;
  logic [CH_W-1:0]           out_chan_q, out_chan_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;

  logic                      en, in_ready, accept, chan_ok;
  logic signed [FullW-1:0]   x_w, st_w, a_w, inv_w, acc_w;
  logic signed [DATA_W-1:0]  y;

  assign en       = !out_valid_q || bus.out_ready;
  // No forwarding: a same-channel sample waits until S1 has written its state back.
  assign in_ready = en && !rst && !clear && !(s1_valid_q && (s1_chan_q == bus.in_chan));
  assign accept   = bus.in_valid && in_ready;
  assign chan_ok  = 32'(bus.in_chan) < CHANNELS;

  always_comb begin
    x_w   = FullW'(s1_x_q);
    st_w  = FullW'(s1_state_q);
    a_w   = FullW'(s1_alpha_q);
    inv_w = Scale - a_w;
    acc_w = a_w * x_w + inv_w * st_w + Half;
    y     = s1_primed_q ? DATA_W'(acc_w >>> ALPHA_W) : s1_x_q;
  end

  always_comb begin
    state_d     = state_q;
    primed_d    = primed_q;
    s1_valid_d  = s1_valid_q;
    s1_chan_d   = s1_chan_q;
    s1_x_d      = s1_x_q;
    s1_alpha_d  = s1_alpha_q;
    s1_primed_d = s1_primed_q;
    s1_state_d  = s1_state_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;

    if (clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      primed_d    = '0;
      for (int i = 0; i < Slots; i++) state_d[i] = '0;
    end else if (en) begin
      // Out-of-range channels are consumed but never enter the pipeline.
      s1_valid_d = accept && chan_ok;
      if (accept) begin
        s1_chan_d   = bus.in_chan;
        s1_x_d      = bus.in_data;
        s1_alpha_d  = bus.in_alpha;
        s1_primed_d = primed_q[bus.in_chan];
        s1_state_d  = state_q[bus.in_chan];
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d          = y;
        out_chan_d          = s1_chan_q;
        state_d[s1_chan_q]  = y;
        primed_d[s1_chan_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Slots; i++) state_q[i] <= '0;
      primed_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_chan_q   <= '0;
      s1_x_q      <= '0;
      s1_alpha_q  <= '0;
      s1_primed_q <= 1'b0;
      s1_state_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      s1_valid_q  <= s1_valid_d;
      s1_chan_q   <= s1_chan_d;
      s1_x_q      <= s1_x_d;
      s1_alpha_q  <= s1_alpha_d;
      s1_primed_q <= s1_primed_d;
      s1_state_q  <= s1_state_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_filter_ewma_mc.sv
// Directed bench for filter_ewma_mc: priming, decay, alpha extremes, signed rounding,
// channel interleave with hazard bubble, backpressure, clear and asynchronous reset.
module tb_filter_ewma_mc;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ALPHA_W  = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int          CH_W     = 2;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  filter_ewma_mc_if #(.DATA_W(DATA_W), .ALPHA_W(ALPHA_W), .CHANNELS(CHANNELS)) bus ();

  filter_ewma_mc #(.DATA_W(DATA_W), .ALPHA_W(ALPHA_W), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int obs_chan[$];
  int obs_data[$];
  int exp_chan[$];
  int exp_data[$];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      obs_chan.push_back(int'(bus.out_chan));
      obs_data.push_back(int'($signed(bus.out_data)));
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input int ch, input int x, input int a);
    bus.in_valid = 1'b1;
    bus.in_chan  = CH_W'(ch);
    bus.in_data  = DATA_W'(x);
    bus.in_alpha = ALPHA_W'(a);
  endtask

  task automatic wait_accept(output int waits);
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (waits >= 50) check_eq("accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int x, input int a);
    int w;
    offer(ch, x, a);
    wait_accept(w);
  endtask

  task automatic expect_out(input int ch, input int d);
    exp_chan.push_back(ch);
    exp_data.push_back(d);
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, "_count"}, obs_chan.size(), exp_chan.size());
    for (int i = 0; i < exp_chan.size() && i < obs_chan.size(); i++) begin
      check_eq($sformatf("%s_chan%0d", tag, i), obs_chan[i], exp_chan[i]);
      check_eq($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    obs_chan.delete();
    obs_data.delete();
    exp_chan.delete();
    exp_data.delete();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    obs_chan.delete();
    obs_data.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int decay[4];
    int chs[6];
    int xs[6];
    int as[6];
    int ws[6];
    int w;

    decay = '{1000, 500, 250, 125};
    chs   = '{0, 1, 2, 3, 0, 0};
    xs    = '{100, -200, 300, 7, 0, 250};
    as    = '{128, 128, 128, 128, 128, 64};
    ws    = '{0, 0, 0, 0, 0, 1};

    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_chan   = '0;
    bus.in_data   = '0;
    bus.in_alpha  = '0;
    bus.out_ready = 1'b1;
    drain(2);

    // Reset state, with a sample offered while rst is high.
    bus.in_valid = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(bus.in_ready), 0);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_out_data", int'(bus.out_data), 0);
    check_eq("rst_out_chan", int'(bus.out_chan), 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Prime and decay on ch0, output exactly two edges after the handshake cycle.
    for (int k = 0; k < 4; k++) begin
      send(0, (k == 0) ? 1000 : 0, 128);
      check_eq($sformatf("decay%0d_early", k), int'(bus.out_valid), 0);
      tick();
      check_eq($sformatf("decay%0d_valid", k), int'(bus.out_valid), 1);
      check_eq($sformatf("decay%0d_data", k), int'($signed(bus.out_data)), decay[k]);
      check_eq($sformatf("decay%0d_chan", k), int'(bus.out_chan), 0);
    end
    drain(2);
    obs_chan.delete();
    obs_data.delete();

    // Alpha extremes on ch1.
    send(1, 0, 77);
    send(1, 1000, 255);
    send(1, -5000, 0);
    drain(4);
    expect_out(1, 0);
    expect_out(1, 996);
    expect_out(1, 996);
    compare_outputs("alpha");

    // Signed rounding on ch2.
    send(2, -1000, 128);
    send(2, 0, 128);
    drain(4);
    expect_out(2, -1000);
    expect_out(2, -500);
    compare_outputs("signed");

    // Interleave with in_valid held high; one bubble before the back-to-back ch0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      offer(chs[i], xs[i], as[i]);
      wait_accept(w);
      check_eq($sformatf("hazard_wait%0d", i), w, ws[i]);
    end
    drain(4);
    expect_out(0, 100);
    expect_out(1, -200);
    expect_out(2, 300);
    expect_out(3, 7);
    expect_out(0, 50);
    expect_out(0, 100);
    compare_outputs("interleave");

    // Backpressure: hold out_ready low for 5 cycles with a sample waiting.
    do_reset();
    send(0, 10, 128);
    send(1, 20, 128);
    send(2, 30, 128);
    bus.out_ready = 1'b0;
    offer(3, 40, 128);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp%0d_in_ready", i), int'(bus.in_ready), 0);
      check_eq($sformatf("bp%0d_valid", i), int'(bus.out_valid), 1);
      check_eq($sformatf("bp%0d_data", i), int'($signed(bus.out_data)), 20);
      check_eq($sformatf("bp%0d_chan", i), int'(bus.out_chan), 1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_accept(w);
    drain(5);
    expect_out(0, 10);
    expect_out(1, 20);
    expect_out(2, 30);
    expect_out(3, 40);
    compare_outputs("backpressure");

    // Clear with two samples in flight, then clear on an idle pipeline with a sample offered.
    do_reset();
    send(0, 100, 128);
    drain(3);
    expect_out(0, 100);
    compare_outputs("clr_prime");
    send(1, 5, 128);
    send(2, 6, 128);
    bus.out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_out_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    drain(3);
    compare_outputs("clr_flush");
    offer(3, 9, 128);
    clear = 1'b1;
    #1;
    check_eq("clr_in_ready", int'(bus.in_ready), 0);
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    drain(3);
    compare_outputs("clr_noaccept");
    send(0, 700, 128);
    drain(3);
    expect_out(0, 700);
    compare_outputs("clr_reprime");

    // Asynchronous reset between clock edges with two samples in flight.
    send(0, 100, 128);
    drain(3);
    expect_out(0, 400);
    compare_outputs("arst_prime");
    send(1, 5, 128);
    send(2, 6, 128);
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", int'(bus.out_valid), 0);
    check_eq("arst_out_data", int'(bus.out_data), 0);
    check_eq("arst_out_chan", int'(bus.out_chan), 0);
    check_eq("arst_in_ready", int'(bus.in_ready), 0);
    #3 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    drain(3);
    compare_outputs("arst_flush");
    send(0, 700, 128);
    drain(3);
    expect_out(0, 700);
    compare_outputs("arst_reprime");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
